sipo_deserializer: RTL and testbench
====================================

Name: sipo_deserializer

Overview:
Parametrised serial-in/parallel-out deserializer, the successor to the team's fixed 4-bit SIPO shift register.
- Width and bit order are set by parameters.
- Bits are accepted only on a bit-enable strobe; an explicit frame-start realigns word boundaries.
- Each completed word is presented on a valid/ready output with a one-word holding register and a sticky overrun flag.
- Sits between a serial link front-end and word-oriented consumers such as FIFOs and register files.

Parameters:
- WIDTH, 8, word width in bits; legal range WIDTH >= 2.
- MSB_FIRST, 1, bit order. 1 = first received bit lands in out_data[WIDTH-1]. 0 = first received bit lands in out_data[0].

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- serial_in  in  1  serial data bit; sampled only when serial_en=1.
- serial_en  in  1  bit strobe; one bit is captured per clk edge while high.
- frame_start  in  1  marks the bit on this cycle as bit 0 of a new word; discards any partial word.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- overrun_clr  in  1  clears the sticky overrun flag.
- out_data  out  WIDTH  last completed word; stable while out_valid=1 and no new word completes.
- out_valid  out  1  holding register full.
- shift_q  out  WIDTH  live partial shift register, for debug.
- bit_cnt  out  $clog2(WIDTH)  number of bits captured in the current word.
- overrun  out  1  sticky; a completed word overwrote an unconsumed word.

Behaviour:
- Reset: when rst=1 at a clk edge, all outputs and state go to 0 on that edge. This has priority over all other inputs and aborts any partial word; the held word is lost.
- Shift, MSB_FIRST=1: shift_q <= {shift_q[WIDTH-2:0], serial_in}.
- Shift, MSB_FIRST=0: shift_q <= {serial_in, shift_q[WIDTH-1:1]}.
- Shifting occurs only on edges where serial_en=1.
- bit_cnt increments on each captured bit and wraps from WIDTH-1 to 0.
- Word completion happens on the edge that captures bit_cnt==WIDTH-1. On that same edge:
  - out_data <= the next-state shift_q value (completed word including this bit);
  - out_valid <= 1;
  - bit_cnt <= 0.
  - Latency: the last serial bit appears in out_data one clk after it is sampled.
- frame_start with serial_en=1: serial_in is taken as bit 0. bit_cnt <= 1 and shift_q holds only that bit in its insert position, other bits 0. The previous partial word is dropped and no completion occurs.
- frame_start with serial_en=0: bit_cnt <= 0, shift_q <= 0.
- Holding register has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- EMPTY to FULL on completion.
- FULL to EMPTY on out_ready=1 with no completion on the same edge.
- FULL with completion and out_ready=1 on the same edge: the old word is consumed, the new word loads, out_valid stays 1, overrun is not set.
- FULL with completion and out_ready=0: the new word overwrites out_data, out_valid stays 1, overrun <= 1.
- out_ready while EMPTY has no effect.
- overrun clears only on rst or overrun_clr=1. If overrun_clr=1 coincides with a new overrun event, the set wins.
- serial_en=0 freezes shift_q and bit_cnt. The holding register can still drain via out_ready.

Decomposition:
- Package sipo_pkg holds:
  - holding-state encoding localparams HOLD_EMPTY=1'b0 and HOLD_FULL=1'b1;
  - a cnt_width(WIDTH) constant function for the bit_cnt width.
- Sub-module sipo_shift_core(WIDTH, MSB_FIRST) contains shift_q, bit_cnt, frame_start handling, and the word_done pulse plus the word bus.
- The top level adds the holding register, out_valid FSM and overrun logic.

Test Plan (WIDTH=4):
- MSB_FIRST=1, out_ready=1, serial_en=1, bits 1,1,0,0 -> out_data=4'b1100, out_valid pulses high for 1 cycle, one clk after the 4th bit.
- MSB_FIRST=0, same bits 1,1,0,0 -> out_data=4'b0011; bit_cnt steps 1,2,3,0.
- out_ready=0, stream words 1010 then 0110 -> after the 2nd word out_data=4'b0110, out_valid=1, overrun=1; pulse overrun_clr -> overrun=0, out_valid remains 1.
- FULL holding 1010, out_ready=1 on the same edge as completion of 0101 -> out_data=4'b0101, out_valid=1, overrun=0.
- frame_start with serial_en=1 after 2 bits of a word, then bits 1,0,0,1 (the frame_start bit is the first 1) -> out_data=4'b1001, no completion from the partial word.
- rst pulse after 3 bits, then 4 bits 0,1,1,1 -> out_data=4'b0111; during rst, outputs are all 0 on the next edge.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared definitions for the SIPO deserializer: holding-register state encoding
// and the bit counter width helper.
package sipo_pkg;

   typedef enum logic {
      HOLD_EMPTY = 1'b0,
      HOLD_FULL  = 1'b1
   } hold_state_t;

   function automatic int cnt_width(input int w);
      return (w < 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/sipo_deserializer_shift_core.sv
// Serial shift register and bit counter with frame realignment; flags each
// completed word and presents it combinationally on word.
module sipo_shift_core
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   input  logic                          serial_en,
   input  logic                          frame_start,
   output logic [WIDTH-1:0]              shift_q,
   output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
   output logic                          word_done,
   output logic [WIDTH-1:0]              word
);

   localparam int            CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] first_bit;
   logic [WIDTH-1:0] shift_nxt;
   logic [CW-1:0]    cnt_nxt;

   // The insert position depends on bit order; a frame-start bit sits alone there.
   always_comb begin
      shifted   = '0;
      first_bit = '0;
      if (MSB_FIRST) begin
         shifted   = {shift_q[WIDTH-2:0], serial_in};
         first_bit = {{(WIDTH-1){1'b0}}, serial_in};
      end else begin
         shifted   = {serial_in, shift_q[WIDTH-1:1]};
         first_bit = {serial_in, {(WIDTH-1){1'b0}}};
      end
   end

   always_comb begin
      shift_nxt = shift_q;
      cnt_nxt   = bit_cnt;
      word_done = 1'b0;
      if (frame_start) begin
         if (serial_en) begin
            shift_nxt = first_bit;
            cnt_nxt   = CW'(1);
         end else begin
            shift_nxt = '0;
            cnt_nxt   = '0;
         end
      end else if (serial_en) begin
         shift_nxt = shifted;
         if (bit_cnt == LAST) begin
            cnt_nxt   = '0;
            word_done = 1'b1;
         end else begin
            cnt_nxt = bit_cnt + CW'(1);
         end
      end
   end

   assign word = shift_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_q <= '0;
         bit_cnt <= '0;
      end else begin
         shift_q <= shift_nxt;
         bit_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/sipo_deserializer.sv
// Parametrised serial-in/parallel-out deserializer with a one-word valid/ready
// holding register and a sticky overrun flag.
module sipo_deserializer
   import sipo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          serial_in,
   input  logic                          serial_en,
   input  logic                          frame_start,
   input  logic                          out_ready,
   input  logic                          overrun_clr,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_valid,
   output logic [WIDTH-1:0]              shift_q,
   output logic [cnt_width(WIDTH)-1:0]   bit_cnt,
   output logic                          overrun
);

   hold_state_t      hold_q;
   hold_state_t      hold_nxt;
   logic             word_done;
   logic [WIDTH-1:0] word;
   logic             set_overrun;

   sipo_shift_core #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST)
   ) u_core (
      .clk         (clk),
      .rst         (rst),
      .serial_in   (serial_in),
      .serial_en   (serial_en),
      .frame_start (frame_start),
      .shift_q     (shift_q),
      .bit_cnt     (bit_cnt),
      .word_done   (word_done),
      .word        (word)
   );

   // A completion while full overwrites the held word; it only counts as an
   // overrun when the consumer is not taking the old word on the same edge.
   always_comb begin
      hold_nxt    = hold_q;
      set_overrun = 1'b0;
      case (hold_q)
         HOLD_EMPTY: begin
            if (word_done) hold_nxt = HOLD_FULL;
         end
         HOLD_FULL: begin
            if (word_done) begin
               set_overrun = ~out_ready;
            end else if (out_ready) begin
               hold_nxt = HOLD_EMPTY;
            end
         end
         default: hold_nxt = HOLD_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hold_q   <= HOLD_EMPTY;
         out_data <= '0;
         overrun  <= 1'b0;
      end else begin
         hold_q <= hold_nxt;
         if (word_done) out_data <= word;
         if (set_overrun)      overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

   assign out_valid = (hold_q == HOLD_FULL);

endmodule

// File: tb/tb_sipo_deserializer.sv
// Checks MSB-first and LSB-first 4-bit deserializers against a bit-history
// reference model using directed scenarios and randomized traffic.
module tb_sipo_deserializer;

   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       serial_in = 1'b0;
   logic       serial_en = 1'b0;
   logic       frame_start = 1'b0;
   logic       out_ready = 1'b0;
   logic       overrun_clr = 1'b0;

   logic [W-1:0] m_data, m_shift, l_data, l_shift;
   logic [1:0]   m_cnt, l_cnt;
   logic         m_valid, m_ovr, l_valid, l_ovr;

   int checks = 0;
   int errors = 0;

   // Reference model state: bits received since the last realignment.
   bit         hist[$];
   int         nbits = 0;
   logic [W-1:0] exp_m_data = '0, exp_l_data = '0;
   logic       exp_valid = 1'b0, exp_ovr = 1'b0;

   always #5 clk = ~clk;

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .serial_en(serial_en),
      .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
      .out_data(m_data), .out_valid(m_valid), .shift_q(m_shift), .bit_cnt(m_cnt),
      .overrun(m_ovr)
   );

   sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst(rst), .serial_in(serial_in), .serial_en(serial_en),
      .frame_start(frame_start), .out_ready(out_ready), .overrun_clr(overrun_clr),
      .out_data(l_data), .out_valid(l_valid), .shift_q(l_shift), .bit_cnt(l_cnt),
      .overrun(l_ovr)
   );

   // Most recent W bits placed by arrival order: newest at bit 0 (MSB-first)
   // or at bit W-1 (LSB-first).
   function automatic logic [W-1:0] exp_shift(input bit msb);
      logic [W-1:0] v = '0;
      int n = hist.size();
      for (int k = 0; k < n; k++) begin
         if (msb) v[k] = hist[n-1-k];
         else     v[W-1-k] = hist[n-1-k];
      end
      return v;
   endfunction

   task automatic model_edge();
      bit done = 1'b0;
      if (rst) begin
         hist.delete();
         nbits = 0; exp_valid = 1'b0; exp_ovr = 1'b0;
         exp_m_data = '0; exp_l_data = '0;
         return;
      end
      if (frame_start) begin
         hist.delete();
         nbits = 0;
         if (serial_en) begin
            hist.push_back(serial_in);
            nbits = 1;
         end
      end else if (serial_en) begin
         hist.push_back(serial_in);
         if (hist.size() > W) void'(hist.pop_front());
         nbits++;
         if (nbits == W) begin
            done = 1'b1;
            nbits = 0;
         end
      end
      if (done) begin
         if (exp_valid && !out_ready) exp_ovr = 1'b1;
         else if (overrun_clr)        exp_ovr = 1'b0;
         exp_m_data = exp_shift(1'b1);
         exp_l_data = exp_shift(1'b0);
         exp_valid  = 1'b1;
      end else begin
         if (overrun_clr) exp_ovr = 1'b0;
         if (exp_valid && out_ready) exp_valid = 1'b0;
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, settle past it.
   task automatic applyStimulus(input bit b, input bit en, input bit fs,
                                input bit rdy, input bit clr, input bit rs);
      serial_in = b; serial_en = en; frame_start = fs;
      out_ready = rdy; overrun_clr = clr; rst = rs;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_word(input logic [3:0] bits, input bit rdy);
      for (int i = 3; i >= 0; i--) applyStimulus(bits[i], 1'b1, 1'b0, rdy, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      checks++;
      if ({m_data, m_valid, m_shift, m_cnt, m_ovr, l_data, l_valid, l_shift, l_cnt, l_ovr} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got m=%h/%b/%h/%0d/%b l=%h/%b/%h/%0d/%b, expected all zero",
                  m_data, m_valid, m_shift, m_cnt, m_ovr, l_data, l_valid, l_shift, l_cnt, l_ovr);
      end
   endtask

   task automatic test_basic_order();
      logic [3:0] bits = 4'b1100;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(bits[3-i], 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (l_cnt !== 2'((i + 1) % 4)) begin
            errors++;
            $display("[TB] FAIL bit_cnt_step%0d: got %0d expected %0d", i, l_cnt, (i + 1) % 4);
         end
      end
      checks++;
      if (m_data !== 4'b1100 || m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL msb_word: got %b valid %b expected 1100 valid 1", m_data, m_valid);
      end
      checks++;
      if (l_data !== 4'b0011 || l_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL lsb_word: got %b valid %b expected 0011 valid 1", l_data, l_valid);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (m_valid !== 1'b0 || l_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL valid_pulse: got %b/%b expected 0/0", m_valid, l_valid);
      end
   endtask

   task automatic test_overrun();
      send_word(4'b1010, 1'b0);
      send_word(4'b0110, 1'b0);
      checks++;
      if (m_data !== 4'b0110 || m_valid !== 1'b1 || m_ovr !== 1'b1) begin
         errors++;
         $display("[TB] FAIL overrun_set: got %b v%b o%b expected 0110 v1 o1", m_data, m_valid, m_ovr);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checks++;
      if (m_ovr !== 1'b0 || m_valid !== 1'b1 || l_ovr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL overrun_clr: got o%b v%b lo%b expected o0 v1 lo0", m_ovr, m_valid, l_ovr);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      send_word(4'b1010, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (m_data !== 4'b1010 || m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL hold_first: got %b v%b expected 1010 v1", m_data, m_valid);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (m_data !== 4'b0101 || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
         errors++;
         $display("[TB] FAIL consume_and_load: got %b v%b o%b expected 0101 v1 o0", m_data, m_valid, m_ovr);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_frame_start();
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (m_cnt !== 2'd1 || m_shift !== 4'b0001 || l_shift !== 4'b1000) begin
         errors++;
         $display("[TB] FAIL frame_realign: got cnt %0d m %b l %b expected 1 0001 1000", m_cnt, m_shift, l_shift);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL no_partial_completion: got valid %b expected 0", m_valid);
      end
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (m_data !== 4'b1001 || m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL frame_word: got %b v%b expected 1001 v1", m_data, m_valid);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midword();
      send_word(4'b1111, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if ({m_data, m_valid, m_shift, m_cnt, m_ovr} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_midword: got %b v%b s%b c%0d o%b expected all zero",
                  m_data, m_valid, m_shift, m_cnt, m_ovr);
      end
      send_word(4'b0111, 1'b0);
      checks++;
      if (m_data !== 4'b0111 || m_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL after_reset_word: got %b v%b expected 0111 v1", m_data, m_valid);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                       1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 60) == 0));
         checks++;
         if (m_data !== exp_m_data || l_data !== exp_l_data || m_valid !== exp_valid ||
             l_valid !== exp_valid || m_ovr !== exp_ovr || l_ovr !== exp_ovr) begin
            errors++;
            $display("[TB] FAIL random_hold cycle %0d: got m%h l%h v%b%b o%b%b expected m%h l%h v%b o%b",
                     i, m_data, l_data, m_valid, l_valid, m_ovr, l_ovr, exp_m_data, exp_l_data,
                     exp_valid, exp_ovr);
         end
         checks++;
         if (m_shift !== exp_shift(1'b1) || l_shift !== exp_shift(1'b0) ||
             m_cnt !== 2'(nbits) || l_cnt !== 2'(nbits)) begin
            errors++;
            $display("[TB] FAIL random_shift cycle %0d: got m%b l%b c%0d/%0d expected m%b l%b c%0d",
                     i, m_shift, l_shift, m_cnt, l_cnt, exp_shift(1'b1), exp_shift(1'b0), nbits);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_order();
      test_overrun();
      test_back_to_back();
      test_frame_start();
      test_reset_midword();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
